// File: rtl/loop_pkg.sv
// Shared types for the nested-loop sequencer: command opcodes and the per-level entry layout.
package loop_pkg;

  localparam int unsigned ITER_BITS_DEF = 18;
  localparam int unsigned DEPTH_DEF     = 8;
  localparam int unsigned LANES_DEF     = 4;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_STEP = 2'd2,
    OP_POP  = 2'd3
  } loop_op_e;

  typedef struct packed {
    logic [ITER_BITS_DEF-1:0] remain;
    logic [ITER_BITS_DEF-1:0] trip;
    logic                     indep;
  } loop_entry_t;

endpackage

// File: rtl/loop_level.sv
// One loop level: remaining/trip counters plus the lane count the next STEP will issue.
module loop_level
  import loop_pkg::*;
#(
  parameter int ITER_BITS = ITER_BITS_DEF,
  parameter int LANES     = LANES_DEF,
  parameter int LW        = $clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 load_i,
  input  logic [ITER_BITS-1:0] count_i,
  input  logic                 indep_i,
  input  logic                 step_i,
  output logic [ITER_BITS-1:0] remain_o,
  output logic [ITER_BITS-1:0] trip_o,
  output logic [LW-1:0]        lane_count_o,
  output logic                 last_o
);

  logic [ITER_BITS-1:0] remain_q, remain_d, trip_q;
  logic                 indep_q;
  logic [ITER_BITS-1:0] issue_w;

  // Dependent levels issue one copy; independent ones issue up to LANES.
  function automatic logic [ITER_BITS-1:0] lanes_avail(input logic [ITER_BITS-1:0] remain,
                                                       input logic indep);
    if (!indep) return ITER_BITS'(1);
    return (remain < ITER_BITS'(LANES)) ? remain : ITER_BITS'(LANES);
  endfunction

  assign issue_w = lanes_avail(remain_q, indep_q);

  always_comb begin
    remain_d = remain_q;
    if (load_i)      remain_d = count_i;
    else if (step_i) remain_d = remain_q - issue_w;
  end

  always_ff @(posedge clk) begin
    remain_q <= remain_d;
    if (load_i) begin
      trip_q  <= count_i;
      indep_q <= indep_i;
    end
  end

  assign remain_o     = remain_q;
  assign trip_o       = trip_q;
  assign lane_count_o = LW'(issue_w);
  assign last_o       = (remain_q <= issue_w);

endmodule

// File: rtl/loop_nest_ctrl.sv
// Nested-loop sequencer: LIFO of loop levels driven by PUSH/STEP/POP with auto-pop and sticky errors.
module loop_nest_ctrl
  import loop_pkg::*;
#(
  parameter int ITER_BITS = ITER_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int LANES     = LANES_DEF,
  localparam int LW       = $clog2(LANES + 1),
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  loop_op_e             cmd_op,
  input  logic [ITER_BITS-1:0] cmd_count,
  input  logic                 cmd_indep,
  output logic [DW-1:0]        depth,
  output logic                 top_valid,
  output logic [ITER_BITS-1:0] top_remain,
  output logic [ITER_BITS-1:0] top_index,
  output logic [LW-1:0]        lane_count,
  output logic                 top_last,
  output logic                 exit_pulse,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 err_zero,
  input  logic                 err_clear
);

  logic [DW-1:0] depth_q;
  logic          exit_q, ovf_q, unf_q, zero_q;

  logic fire, empty, full, is_push, is_step, is_pop;
  logic push_ok, step_ok, pop_ok, auto_pop, zero_ev, ovf_ev, unf_ev;

  logic [ITER_BITS-1:0] lvl_remain [DEPTH];
  logic [ITER_BITS-1:0] lvl_trip   [DEPTH];
  logic [LW-1:0]        lvl_lanes  [DEPTH];
  logic                 lvl_last   [DEPTH];

  assign cmd_ready = ~reset & ~flush;
  assign fire      = cmd_valid & cmd_ready;
  assign empty     = (depth_q == '0);
  assign full      = (depth_q == DW'(DEPTH));
  assign is_push   = fire & (cmd_op == OP_PUSH);
  assign is_step   = fire & (cmd_op == OP_STEP);
  assign is_pop    = fire & (cmd_op == OP_POP);

  assign push_ok  = is_push & (cmd_count != '0) & ~full;
  assign step_ok  = is_step & ~empty;
  assign pop_ok   = is_pop & ~empty;
  assign auto_pop = step_ok & top_last;
  assign zero_ev  = is_push & (cmd_count == '0);
  assign ovf_ev   = is_push & (cmd_count != '0) & full;
  assign unf_ev   = (is_step | is_pop) & empty;

  // Level g is loaded when it becomes the new top and stepped only while it is the top.
  for (genvar g = 0; g < DEPTH; g++) begin : g_lvl
    loop_level #(
      .ITER_BITS(ITER_BITS),
      .LANES    (LANES),
      .LW       (LW)
    ) u_lvl (
      .clk         (clk),
      .load_i      (push_ok & (depth_q == DW'(g))),
      .count_i     (cmd_count),
      .indep_i     (cmd_indep),
      .step_i      (step_ok & (depth_q == DW'(g + 1))),
      .remain_o    (lvl_remain[g]),
      .trip_o      (lvl_trip[g]),
      .lane_count_o(lvl_lanes[g]),
      .last_o      (lvl_last[g])
    );
  end

  always_comb begin
    top_remain = '0;
    top_index  = '0;
    lane_count = '0;
    top_last   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        top_remain = lvl_remain[i];
        top_index  = lvl_trip[i] - lvl_remain[i];
        lane_count = lvl_lanes[i];
        top_last   = lvl_last[i];
      end
    end
  end

  // Flush empties the stack but leaves the sticky errors alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      exit_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      ovf_q  <= (ovf_q & ~err_clear) | ovf_ev;
      unf_q  <= (unf_q & ~err_clear) | unf_ev;
      zero_q <= (zero_q & ~err_clear) | zero_ev;
      if (flush) begin
        depth_q <= '0;
        exit_q  <= 1'b0;
      end else begin
        exit_q <= pop_ok | auto_pop;
        if (push_ok)                depth_q <= depth_q + DW'(1);
        else if (pop_ok | auto_pop) depth_q <= depth_q - DW'(1);
      end
    end
  end

  assign depth         = depth_q;
  assign top_valid     = ~empty;
  assign exit_pulse    = exit_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_zero      = zero_q;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Directed bench for loop_nest_ctrl with a queue-based reference model checked every cycle.
module tb_loop_nest_ctrl;
  import loop_pkg::*;

  localparam int IB = 18;
  localparam int DP = 2;
  localparam int LN = 4;
  localparam int LW = $clog2(LN + 1);
  localparam int DW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset, flush, cmd_valid, cmd_indep, err_clear;
  loop_op_e      cmd_op;
  logic [IB-1:0] cmd_count;
  logic          cmd_ready, top_valid, top_last, exit_pulse;
  logic          err_overflow, err_underflow, err_zero;
  logic [DW-1:0] depth;
  logic [IB-1:0] top_remain, top_index;
  logic [LW-1:0] lane_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  loop_nest_ctrl #(.ITER_BITS(IB), .DEPTH(DP), .LANES(LN)) dut (
    .clk(clk), .reset(reset), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_indep(cmd_indep), .depth(depth),
    .top_valid(top_valid), .top_remain(top_remain), .top_index(top_index),
    .lane_count(lane_count), .top_last(top_last), .exit_pulse(exit_pulse),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_zero(err_zero),
    .err_clear(err_clear)
  );

  // Reference model: the loop stack as a queue of levels, innermost at the back.
  typedef struct {
    int remain;
    int trip;
    bit indep;
  } ent_t;

  ent_t q[$];
  bit   m_exit, m_ovf, m_unf, m_zero;
  bit   started = 0;

  function automatic int lanes_of(input int remain, input bit indep);
    if (!indep) return 1;
    return (remain < LN) ? remain : LN;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit ez, eo, eu;
    int n, lc;
    ez = 0; eo = 0; eu = 0;
    if (reset) begin
      q.delete();
      m_exit = 0; m_ovf = 0; m_unf = 0; m_zero = 0;
      started = 1;
    end else begin
      m_exit = 0;
      n = q.size();
      if (!flush && cmd_valid) begin
        case (cmd_op)
          OP_PUSH: begin
            if (cmd_count == 0) ez = 1;
            else if (n == DP) eo = 1;
            else q.push_back('{remain: int'(cmd_count), trip: int'(cmd_count), indep: cmd_indep});
          end
          OP_STEP: begin
            if (n == 0) eu = 1;
            else begin
              lc = lanes_of(q[n-1].remain, q[n-1].indep);
              q[n-1].remain = q[n-1].remain - lc;
              if (q[n-1].remain == 0) begin
                void'(q.pop_back());
                m_exit = 1;
              end
            end
          end
          OP_POP: begin
            if (n == 0) eu = 1;
            else begin
              void'(q.pop_back());
              m_exit = 1;
            end
          end
          default: ;
        endcase
      end else if (flush) begin
        q.delete();
      end
      m_ovf  = (m_ovf && !err_clear) || eo;
      m_unf  = (m_unf && !err_clear) || eu;
      m_zero = (m_zero && !err_clear) || ez;
    end
  end

  always @(negedge clk) begin
    int n, er, ei, el, et;
    if (started) begin
      n = q.size();
      er = 0; ei = 0; el = 0; et = 0;
      if (n != 0) begin
        er = q[n-1].remain;
        ei = q[n-1].trip - q[n-1].remain;
        el = lanes_of(er, q[n-1].indep);
        et = (er <= el) ? 1 : 0;
      end
      check("m_depth", int'(depth), n);
      check("m_top_valid", int'(top_valid), (n != 0) ? 1 : 0);
      check("m_top_remain", int'(top_remain), er);
      check("m_top_index", int'(top_index), ei);
      check("m_lane_count", int'(lane_count), el);
      check("m_top_last", int'(top_last), et);
      check("m_exit_pulse", int'(exit_pulse), int'(m_exit));
      check("m_err_overflow", int'(err_overflow), int'(m_ovf));
      check("m_err_underflow", int'(err_underflow), int'(m_unf));
      check("m_err_zero", int'(err_zero), int'(m_zero));
      check("m_cmd_ready", int'(cmd_ready), (!reset && !flush) ? 1 : 0);
    end
  end

  task automatic idle_inputs();
    cmd_valid = 0; cmd_op = OP_NOP; cmd_count = '0; cmd_indep = 0; flush = 0; err_clear = 0;
  endtask

  task automatic drive(input loop_op_e op, input int cnt, input bit ind,
                       input bit fl = 0, input bit clr = 0);
    cmd_valid = 1; cmd_op = op; cmd_count = IB'(cnt); cmd_indep = ind;
    flush = fl; err_clear = clr;
    @(posedge clk); #2;
    idle_inputs();
  endtask

  task automatic idle();
    @(posedge clk); #2;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    @(posedge clk); #2;
    check("rst_ready_low", int'(cmd_ready), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_errs", int'({err_overflow, err_underflow, err_zero}), 0);
    reset = 0;
    #1 check("rst_ready_high", int'(cmd_ready), 1);
    idle();

    // Flat loop
    drive(OP_PUSH, 5, 0);
    check("flat_depth", int'(depth), 1);
    check("flat_remain", int'(top_remain), 5);
    check("flat_lanes", int'(lane_count), 1);
    for (int i = 0; i < 5; i++) begin
      check("flat_index", int'(top_index), i);
      check("flat_last", int'(top_last), (i == 4) ? 1 : 0);
      drive(OP_STEP, 0, 0);
    end
    check("flat_exit", int'(exit_pulse), 1);
    check("flat_depth_end", int'(depth), 0);
    idle();
    check("flat_exit_clr", int'(exit_pulse), 0);

    // Independent loop with a partial tail
    drive(OP_PUSH, 10, 1);
    check("ind_lanes0", int'(lane_count), 4);
    drive(OP_STEP, 0, 0);
    check("ind_lanes1", int'(lane_count), 4);
    check("ind_index1", int'(top_index), 4);
    check("ind_last1", int'(top_last), 0);
    drive(OP_STEP, 0, 0);
    check("ind_lanes2", int'(lane_count), 2);
    check("ind_remain2", int'(top_remain), 2);
    check("ind_last2", int'(top_last), 1);
    drive(OP_STEP, 0, 0);
    check("ind_exit", int'(exit_pulse), 1);
    check("ind_depth", int'(depth), 0);

    // Nesting and overflow
    drive(OP_PUSH, 3, 0);
    drive(OP_PUSH, 2, 0);
    drive(OP_PUSH, 7, 0);
    check("ovf_flag", int'(err_overflow), 1);
    check("ovf_depth", int'(depth), 2);
    check("ovf_remain", int'(top_remain), 2);
    drive(OP_POP, 0, 0);
    check("ovf_outer_remain", int'(top_remain), 3);
    check("ovf_pop_exit", int'(exit_pulse), 1);
    drive(OP_POP, 0, 0);
    drive(OP_NOP, 0, 0, 0, 1);
    check("ovf_cleared", int'(err_overflow), 0);

    // Underflow, zero count, clear priority
    drive(OP_STEP, 0, 0);
    check("unf_flag", int'(err_underflow), 1);
    drive(OP_PUSH, 0, 0);
    check("zero_flag", int'(err_zero), 1);
    check("zero_depth", int'(depth), 0);
    drive(OP_NOP, 0, 0, 0, 1);
    check("clr_unf", int'(err_underflow), 0);
    check("clr_zero", int'(err_zero), 0);
    drive(OP_POP, 0, 0, 0, 1);
    check("clr_vs_new", int'(err_underflow), 1);
    drive(OP_NOP, 0, 0, 0, 1);

    // Early break from a nested level
    drive(OP_PUSH, 6, 0);
    drive(OP_PUSH, 4, 0);
    drive(OP_STEP, 0, 0);
    check("brk_remain", int'(top_remain), 3);
    check("brk_index", int'(top_index), 1);
    drive(OP_POP, 0, 0);
    check("brk_exit", int'(exit_pulse), 1);
    check("brk_depth", int'(depth), 1);
    check("brk_outer", int'(top_remain), 6);
    check("brk_outer_idx", int'(top_index), 0);
    drive(OP_POP, 0, 0);
    check("brk_empty", int'(depth), 0);

    // Flush with a same-cycle STEP
    drive(OP_PUSH, 0, 0);
    drive(OP_PUSH, 9, 0);
    drive(OP_PUSH, 9, 0);
    cmd_valid = 1; cmd_op = OP_STEP; flush = 1;
    #1 check("fl_ready_low", int'(cmd_ready), 0);
    @(posedge clk); #2;
    idle_inputs();
    check("fl_depth", int'(depth), 0);
    check("fl_exit", int'(exit_pulse), 0);
    check("fl_err_kept", int'(err_zero), 1);
    idle();
    check("fl_depth_hold", int'(depth), 0);
    drive(OP_NOP, 0, 0, 0, 1);

    // Reset in the middle of a loop
    drive(OP_PUSH, 5, 1);
    drive(OP_STEP, 0, 0);
    check("rm_remain", int'(top_remain), 1);
    check("rm_lanes", int'(lane_count), 1);
    drive(OP_PUSH, 0, 0);
    reset = 1; cmd_valid = 1; cmd_op = OP_PUSH; cmd_count = IB'(3); err_clear = 0;
    #1 check("rm_ready_low", int'(cmd_ready), 0);
    @(posedge clk); #2;
    idle_inputs();
    reset = 0;
    check("rm_depth", int'(depth), 0);
    check("rm_valid", int'(top_valid), 0);
    check("rm_remain0", int'(top_remain), 0);
    check("rm_index0", int'(top_index), 0);
    check("rm_lanes0", int'(lane_count), 0);
    check("rm_last0", int'(top_last), 0);
    check("rm_exit0", int'(exit_pulse), 0);
    check("rm_errs0", int'({err_overflow, err_underflow, err_zero}), 0);
    #1 check("rm_ready_high", int'(cmd_ready), 1);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
